digital_lock_lockout: RTL

Second-generation keypad lock state machine: sets a passcode by double entry while unlocked, unlocks on matching entry while locked. Generalised over key count and passcode length. Adds an inter-digit entry timeout and a brute-force lockout after repeated failed unlock attempts. Sits between the debounced push-button inputs and the lock/status indicators in the top level.

---
 rtl/digital_lock_defs.sv | 26 ++
 rtl/digital_lock_lockout_key_press_decoder.sv | 40 ++++
 rtl/digital_lock_lockout.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/digital_lock_defs.sv
// Shared definitions for the keypad lock: FSM state encoding, key index width
// and time-to-cycle conversion helpers.
package digital_lock_defs;

    typedef enum logic [1:0] {
        S_UNLOCKED = 2'd0,
        S_CONFIRM  = 2'd1,
        S_LOCKED   = 2'd2,
        S_LOCKOUT  = 2'd3
    } lock_state_t;

    // Bits needed to hold the index of one of n one-hot keys.
    function automatic int key_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic longint sec_to_cycles(input longint freq, input longint sec);
        return freq * sec;
    endfunction

    // Counter width able to reach the value n - 1 (never narrower than 1 bit).
    function automatic int cnt_w(input longint n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digital_lock_lockout_key_press_decoder.sv
// Key input stage: registers the previous key level and decodes a fresh press
// into a digit index plus a flag for multi-key (invalid) presses.
module key_press_decoder
    import digital_lock_defs::*;
#(
    parameter int NUM_KEYS = 4,
    parameter int KEY_W    = key_w(NUM_KEYS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key,
    output logic                press,
    output logic [KEY_W-1:0]    digit,
    output logic                invalid
);

    logic [NUM_KEYS-1:0] key_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_q <= '0;
        end else begin
            key_q <= key;
        end
    end

    // A press needs an all-released previous sample, so rolling between keys is ignored.
    assign press   = (key != '0) && (key_q == '0);
    assign invalid = (key & (key - NUM_KEYS'(1))) != '0;

    always_comb begin
        digit = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key[i]) begin
                digit = KEY_W'(i);
            end
        end
    end

endmodule

// File: rtl/digital_lock_lockout.sv
// Keypad lock FSM: passcode set by double entry, unlock by matching entry,
// inter-digit timeout and brute-force lockout after repeated failures.
module digital_lock_lockout
    import digital_lock_defs::*;
#(
    parameter int CLOCK_FREQ      = 50000000,
    parameter int NUM_KEYS        = 4,
    parameter int PASSCODE_LENGTH = 3,
    parameter int TIMEOUT_SEC     = 5,
    parameter int MAX_ATTEMPTS    = 3,
    parameter int LOCKOUT_SEC     = 30
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUM_KEYS-1:0]                  key,
    output logic                                 locked,
    output logic                                 error,
    output logic                                 lockout,
    output logic [$clog2(PASSCODE_LENGTH+1)-1:0] digit_count
);

    localparam int     KEY_W          = key_w(NUM_KEYS);
    localparam int     CODE_W         = PASSCODE_LENGTH * KEY_W;
    localparam int     CNT_W          = $clog2(PASSCODE_LENGTH + 1);
    localparam int     FAIL_W         = $clog2(MAX_ATTEMPTS + 1);
    localparam longint TIMEOUT_CYCLES = sec_to_cycles(longint'(CLOCK_FREQ), longint'(TIMEOUT_SEC));
    localparam longint LOCKOUT_CYCLES = sec_to_cycles(longint'(CLOCK_FREQ), longint'(LOCKOUT_SEC));
    localparam int     TO_W           = cnt_w(TIMEOUT_CYCLES);
    localparam int     LO_W           = cnt_w(LOCKOUT_CYCLES);

    logic               press;
    logic [KEY_W-1:0]   digit;
    logic               invalid;

    lock_state_t        state, state_nxt;
    logic [CNT_W-1:0]   count_q, count_nxt;
    logic [CODE_W-1:0]  entry, entry_nxt;
    logic [CODE_W-1:0]  new_code, new_code_nxt;
    logic [CODE_W-1:0]  passcode, passcode_nxt;
    logic               poison, poison_nxt;
    logic [FAIL_W-1:0]  fail_count, fail_nxt, fail_inc;
    logic               error_q, error_nxt;
    logic [TO_W-1:0]    to_timer, to_timer_nxt;
    logic [LO_W-1:0]    lo_timer, lo_timer_nxt;
    logic               cmp_p1, cmp_p1_nxt;
    logic               vld_p1, vld_p1_nxt;
    logic [CODE_W-1:0]  shifted;
    logic [CODE_W-1:0]  ref_code;

    key_press_decoder #(
        .NUM_KEYS (NUM_KEYS),
        .KEY_W    (KEY_W)
    ) u_dec (
        .clock   (clock),
        .reset   (reset),
        .key     (key),
        .press   (press),
        .digit   (digit),
        .invalid (invalid)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_UNLOCKED;
            count_q    <= '0;
            entry      <= '0;
            new_code   <= '0;
            passcode   <= '0;
            poison     <= 1'b0;
            fail_count <= '0;
            error_q    <= 1'b0;
            to_timer   <= '0;
            lo_timer   <= '0;
            cmp_p1     <= 1'b0;
            vld_p1     <= 1'b0;
        end else begin
            state      <= state_nxt;
            count_q    <= count_nxt;
            entry      <= entry_nxt;
            new_code   <= new_code_nxt;
            passcode   <= passcode_nxt;
            poison     <= poison_nxt;
            fail_count <= fail_nxt;
            error_q    <= error_nxt;
            to_timer   <= to_timer_nxt;
            lo_timer   <= lo_timer_nxt;
            cmp_p1     <= cmp_p1_nxt;
            vld_p1     <= vld_p1_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        count_nxt    = count_q;
        entry_nxt    = entry;
        new_code_nxt = new_code;
        passcode_nxt = passcode;
        poison_nxt   = poison;
        fail_nxt     = fail_count;
        error_nxt    = error_q;
        to_timer_nxt = to_timer;
        lo_timer_nxt = lo_timer;
        cmp_p1_nxt   = 1'b0;
        vld_p1_nxt   = 1'b0;
        shifted      = (entry << KEY_W) | CODE_W'(digit);
        ref_code     = (state == S_CONFIRM) ? new_code : passcode;
        fail_inc     = (fail_count == FAIL_W'(MAX_ATTEMPTS)) ? fail_count : fail_count + FAIL_W'(1);

        if (state == S_LOCKOUT) begin
            if (lo_timer == LO_W'(LOCKOUT_CYCLES - 1)) begin
                state_nxt    = S_LOCKED;
                fail_nxt     = '0;
                error_nxt    = 1'b0;
                lo_timer_nxt = '0;
            end else begin
                lo_timer_nxt = lo_timer + LO_W'(1);
            end
        // ---- p1: act on the compare registered with the final digit ----
        end else if (vld_p1) begin
            count_nxt    = '0;
            entry_nxt    = '0;
            poison_nxt   = 1'b0;
            to_timer_nxt = '0;
            case (state)
                S_UNLOCKED: begin
                    new_code_nxt = entry;
                    state_nxt    = S_CONFIRM;
                end
                S_CONFIRM: begin
                    if (cmp_p1) begin
                        passcode_nxt = new_code;
                        state_nxt    = S_LOCKED;
                    end else begin
                        error_nxt = 1'b0 | 1'b1;
                        state_nxt = S_UNLOCKED;
                    end
                end
                default: begin
                    if (cmp_p1) begin
                        fail_nxt  = '0;
                        state_nxt = S_UNLOCKED;
                    end else begin
                        error_nxt = 1'b1;
                        fail_nxt  = fail_inc;
                        if (fail_inc == FAIL_W'(MAX_ATTEMPTS)) begin
                            state_nxt    = S_LOCKOUT;
                            lo_timer_nxt = '0;
                        end
                    end
                end
            endcase
        // ---- p0: digit capture; a press beats a timeout on the same edge ----
        end else if (press) begin
            error_nxt    = 1'b0;
            count_nxt    = count_q + CNT_W'(1);
            entry_nxt    = shifted;
            poison_nxt   = poison | invalid;
            to_timer_nxt = '0;
            if (count_q == CNT_W'(PASSCODE_LENGTH - 1)) begin
                vld_p1_nxt = 1'b1;
                cmp_p1_nxt = !(poison | invalid) && (shifted == ref_code);
            end
        end else if (count_q != '0) begin
            if (to_timer == TO_W'(TIMEOUT_CYCLES - 1)) begin
                count_nxt    = '0;
                entry_nxt    = '0;
                poison_nxt   = 1'b0;
                to_timer_nxt = '0;
                if (state == S_CONFIRM) begin
                    state_nxt    = S_UNLOCKED;
                    new_code_nxt = '0;
                end
            end else begin
                to_timer_nxt = to_timer + TO_W'(1);
            end
        end
    end

    assign locked      = (state == S_LOCKED) || (state == S_LOCKOUT);
    assign lockout     = (state == S_LOCKOUT);
    assign error       = error_q;
    assign digit_count = count_q;

endmodule
